// File: rtl/csa_accumulator.sv
// csa_accumulator
// Accumulates a packet of redundant (sum, carry) beats in carry-save form,
// then resolves the pair with a single carry-propagate add on the packet's
// last beat. The result is optionally clamped to the signed OUT_SIZE range
// and held on a valid/ready output port until downstream takes it.
// A small sim-only checker module at the end of this file guards the
// output-hold contract.

module csa_accumulator #(
  parameter int IN_SIZE   = 16,
  parameter int ACC_WIDTH = 32,
  parameter int OUT_SIZE  = 24,
  parameter bit SATURATE  = 1'b1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [IN_SIZE-1:0]  in_sum_i,
  input  logic [IN_SIZE-1:0]  in_carry_i,
  input  logic                in_last_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [OUT_SIZE-1:0] out_data_o,
  output logic                out_sat_o,
  output logic                busy_o
);

  // Width of the bits that must all equal the sign bit for r to fit in OUT_SIZE.
  localparam int HI_W = ACC_WIDTH - OUT_SIZE + 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCUM   = 2'd1,
    ST_RESOLVE = 2'd2,
    ST_OUTPUT  = 2'd3
  } state_t;

  // ---------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------

  // Two's complement sign extension of an input word to accumulator width.
  function automatic logic [ACC_WIDTH-1:0] sext_in(input logic [IN_SIZE-1:0] v);
    return {{(ACC_WIDTH-IN_SIZE){v[IN_SIZE-1]}}, v};
  endfunction

  // Majority (carry) of three vectors, bitwise.
  function automatic logic [ACC_WIDTH-1:0] maj3(input logic [ACC_WIDTH-1:0] a,
                                                input logic [ACC_WIDTH-1:0] b,
                                                input logic [ACC_WIDTH-1:0] c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Shift left by one bit; the bit leaving the top is dropped (mod 2^ACC_WIDTH).
  function automatic logic [ACC_WIDTH-1:0] shl1(input logic [ACC_WIDTH-1:0] v);
    return {v[ACC_WIDTH-2:0], 1'b0};
  endfunction

  // 4:2 compressor built from two chained full-adder rows.
  // Returns {sum, carry}; sum + carry == a + b + c + d (mod 2^ACC_WIDTH).
  function automatic logic [2*ACC_WIDTH-1:0] compress_4to2(input logic [ACC_WIDTH-1:0] a,
                                                           input logic [ACC_WIDTH-1:0] b,
                                                           input logic [ACC_WIDTH-1:0] c,
                                                           input logic [ACC_WIDTH-1:0] d);
    logic [ACC_WIDTH-1:0] s1;
    logic [ACC_WIDTH-1:0] c1;
    logic [ACC_WIDTH-1:0] s2;
    logic [ACC_WIDTH-1:0] c2;
    s1 = a ^ b ^ c;
    c1 = shl1(maj3(a, b, c));
    s2 = s1 ^ c1 ^ d;
    c2 = shl1(maj3(s1, c1, d));
    return {s2, c2};
  endfunction

  // Narrow the resolved ACC_WIDTH value to OUT_SIZE. Returns {sat, data}.
  // r fits when its top HI_W bits are all copies of the sign bit.
  function automatic logic [OUT_SIZE:0] narrow(input logic [ACC_WIDTH-1:0] r);
    logic [HI_W-1:0]     hi;
    logic [OUT_SIZE-1:0] max_v;
    logic [OUT_SIZE-1:0] min_v;
    logic [OUT_SIZE:0]   res;
    hi    = r[ACC_WIDTH-1:OUT_SIZE-1];
    max_v = {1'b0, {(OUT_SIZE-1){1'b1}}};
    min_v = {1'b1, {(OUT_SIZE-1){1'b0}}};
    if (!SATURATE) begin
      res = {1'b0, r[OUT_SIZE-1:0]};
    end else if ((hi == {HI_W{1'b0}}) || (hi == {HI_W{1'b1}})) begin
      res = {1'b0, r[OUT_SIZE-1:0]};
    end else if (r[ACC_WIDTH-1] == 1'b0) begin
      res = {1'b1, max_v};
    end else begin
      res = {1'b1, min_v};
    end
    return res;
  endfunction

  // ---------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------
  state_t                state_r;
  logic [ACC_WIDTH-1:0]  acc_sum_r;
  logic [ACC_WIDTH-1:0]  acc_carry_r;
  logic                  in_ready_r;
  logic                  out_valid_r;
  logic [OUT_SIZE-1:0]   out_data_r;
  logic                  out_sat_r;
  logic                  busy_r;

  // Combinational datapath
  logic                  accept_s;
  logic [ACC_WIDTH-1:0]  op_sum_s;
  logic [ACC_WIDTH-1:0]  op_carry_s;
  logic [2*ACC_WIDTH-1:0] compressed_s;
  logic [ACC_WIDTH-1:0]  next_sum_s;
  logic [ACC_WIDTH-1:0]  next_carry_s;
  logic [ACC_WIDTH-1:0]  resolved_s;
  logic [OUT_SIZE:0]     narrowed_s;

  // Beat handshake; ready is a register so out_ready_i never reaches it combinationally.
  always_comb begin
    accept_s = in_valid_i & in_ready_r;
  end

  // A packet starting from IDLE ignores leftover accumulator contents.
  always_comb begin
    if (state_r == ST_IDLE) begin
      op_sum_s   = {ACC_WIDTH{1'b0}};
      op_carry_s = {ACC_WIDTH{1'b0}};
    end else begin
      op_sum_s   = acc_sum_r;
      op_carry_s = acc_carry_r;
    end
  end

  // Fold the incoming beat into the carry-save pair without carry propagation.
  always_comb begin
    compressed_s = compress_4to2(op_sum_s, op_carry_s, sext_in(in_sum_i), sext_in(in_carry_i));
    next_sum_s   = compressed_s[2*ACC_WIDTH-1:ACC_WIDTH];
    next_carry_s = compressed_s[ACC_WIDTH-1:0];
  end

  // Single carry-propagate add and narrowing used in RESOLVE.
  always_comb begin
    resolved_s = acc_sum_r + acc_carry_r;
    narrowed_s = narrow(resolved_s);
  end

  // Control FSM with all outputs registered.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r     <= ST_IDLE;
      acc_sum_r   <= {ACC_WIDTH{1'b0}};
      acc_carry_r <= {ACC_WIDTH{1'b0}};
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      out_data_r  <= {OUT_SIZE{1'b0}};
      out_sat_r   <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_ACCUM: begin
          if (accept_s) begin
            acc_sum_r   <= next_sum_s;
            acc_carry_r <= next_carry_s;
            busy_r      <= 1'b1;
            if (in_last_i) begin
              state_r    <= ST_RESOLVE;
              in_ready_r <= 1'b0;
            end else begin
              state_r    <= ST_ACCUM;
            end
          end else begin
            state_r <= state_r;
          end
        end
        ST_RESOLVE: begin
          out_data_r  <= narrowed_s[OUT_SIZE-1:0];
          out_sat_r   <= narrowed_s[OUT_SIZE];
          out_valid_r <= 1'b1;
          state_r     <= ST_OUTPUT;
        end
        ST_OUTPUT: begin
          if (out_ready_i) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
            state_r     <= ST_IDLE;
          end else begin
            state_r <= ST_OUTPUT;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready_o  = in_ready_r;
  assign out_valid_o = out_valid_r;
  assign out_data_o  = out_data_r;
  assign out_sat_o   = out_sat_r;
  assign busy_o      = busy_r;

  csa_accumulator_checker #(
    .OUT_SIZE (OUT_SIZE),
    .SATURATE (SATURATE)
  ) u_checker (
    .clk       (clk_i),
    .rst       (rst_i),
    .in_ready  (in_ready_r),
    .out_valid (out_valid_r),
    .out_ready (out_ready_i),
    .out_data  (out_data_r),
    .out_sat   (out_sat_r)
  );

endmodule

// csa_accumulator_checker
// Simulation-only protocol properties for csa_accumulator's output port.
module csa_accumulator_checker #(
  parameter int OUT_SIZE = 24,
  parameter bit SATURATE = 1'b1
) (
  input logic                clk,
  input logic                rst,
  input logic                in_ready,
  input logic                out_valid,
  input logic                out_ready,
  input logic [OUT_SIZE-1:0] out_data,
  input logic                out_sat
);

  // A presented result must hold until it is taken.
  property p_out_hold;
    @(posedge clk) disable iff (rst)
      (out_valid && !out_ready) |=> (out_valid && $stable(out_data) && $stable(out_sat));
  endproperty
  a_out_hold: assert property (p_out_hold);

  // The block never accepts a beat while a result is pending.
  property p_no_overlap;
    @(posedge clk) disable iff (rst) !(in_ready && out_valid);
  endproperty
  a_no_overlap: assert property (p_no_overlap);

  // Without saturation the flag stays low.
  property p_sat_off;
    @(posedge clk) disable iff (rst) (!SATURATE) |-> !out_sat;
  endproperty
  a_sat_off: assert property (p_sat_off);

endmodule

// File: tb/tb_csa_accumulator.sv
// Scoreboard bench for csa_accumulator: two instances (saturating and
// wrapping) share stimulus; expected results come from a plain-integer
// model of the packet sum and are queued at the last-beat handshake.
module tb_csa_accumulator;

  localparam int IN_W  = 16;
  localparam int ACC_W = 32;
  localparam int OUT_W = 24;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic [IN_W-1:0]  in_sum = '0;
  logic [IN_W-1:0]  in_carry = '0;
  logic             in_last = 1'b0;
  logic             out_ready = 1'b0;

  logic             in_ready_s, in_ready_w;
  logic             out_valid_s, out_valid_w;
  logic [OUT_W-1:0] out_data_s, out_data_w;
  logic             out_sat_s, out_sat_w;
  logic             busy_s, busy_w;

  int n_checks = 0;
  int n_fail   = 0;
  int ready_mode = 1;          // 0: hold low, 1: hold high, 2: random

  longint           model_acc = 0;   // true sum of the packet in progress
  logic [OUT_W:0]   q_sat[$];
  logic [OUT_W:0]   q_wrap[$];

  csa_accumulator #(.IN_SIZE(IN_W), .ACC_WIDTH(ACC_W), .OUT_SIZE(OUT_W), .SATURATE(1'b1)) dut_sat (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready_s),
    .in_sum_i(in_sum), .in_carry_i(in_carry), .in_last_i(in_last),
    .out_valid_o(out_valid_s), .out_ready_i(out_ready), .out_data_o(out_data_s),
    .out_sat_o(out_sat_s), .busy_o(busy_s));

  csa_accumulator #(.IN_SIZE(IN_W), .ACC_WIDTH(ACC_W), .OUT_SIZE(OUT_W), .SATURATE(1'b0)) dut_wrap (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready_w),
    .in_sum_i(in_sum), .in_carry_i(in_carry), .in_last_i(in_last),
    .out_valid_o(out_valid_w), .out_ready_i(out_ready), .out_data_o(out_data_w),
    .out_sat_o(out_sat_w), .busy_o(busy_w));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Reference: wrap the true sum to ACC_W bits, then clamp or truncate to OUT_W.
  function automatic logic [OUT_W:0] ref_result(input longint total, input bit sat_en);
    logic signed [ACC_W-1:0] w;
    longint v;
    longint hi;
    longint lo;
    logic [63:0] hv;
    logic [63:0] lv;
    logic [63:0] vv;
    hi = (longint'(1) <<< (OUT_W-1)) - 1;
    lo = -(longint'(1) <<< (OUT_W-1));
    w  = total[ACC_W-1:0];
    v  = w;
    hv = hi; lv = lo; vv = v;
    if (sat_en && v > hi) return {1'b1, hv[OUT_W-1:0]};
    else if (sat_en && v < lo) return {1'b1, lv[OUT_W-1:0]};
    else return {1'b0, vv[OUT_W-1:0]};
  endfunction

  // Offer one beat after 'gap' idle cycles; hold it until accepted.
  task automatic send_beat(input logic [IN_W-1:0] s, input logic [IN_W-1:0] c,
                           input bit last, input int gap);
    int waited;
    repeat (gap) @(negedge clk);
    in_valid = 1'b1; in_sum = s; in_carry = c; in_last = last;
    waited = 0;
    while (!in_ready_s && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready_s) begin
      fail_now("accept_timeout");
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    model_acc += longint'({{(64-IN_W){s[IN_W-1]}}, s}) + longint'({{(64-IN_W){c[IN_W-1]}}, c});
    if (last) begin
      q_sat.push_back(ref_result(model_acc, 1'b1));
      q_wrap.push_back(ref_result(model_acc, 1'b0));
      model_acc = 0;
    end
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic drain();
    int waited = 0;
    while ((q_sat.size() != 0 || q_wrap.size() != 0) && waited < 5000) begin
      @(negedge clk);
      waited++;
    end
    if (q_sat.size() != 0 || q_wrap.size() != 0) fail_now("drain_timeout");
  endtask

  // Downstream ready driver, updated just after each rising edge.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: on every output handshake pop and compare the expected result.
  always @(negedge clk) begin
    if (!rst && out_valid_s && out_ready) begin
      if (q_sat.size() == 0) fail_now("sat_unexpected_output");
      else check("sat_result", {out_sat_s, out_data_s}, q_sat.pop_front());
    end
    if (!rst && out_valid_w && out_ready) begin
      if (q_wrap.size() == 0) fail_now("wrap_unexpected_output");
      else check("wrap_result", {out_sat_w, out_data_w}, q_wrap.pop_front());
    end
  end

  initial begin
    int waited;
    // Reset values
    #12;
    check("rst_in_ready", in_ready_s, 1'b1);
    check("rst_out_valid", out_valid_s, 1'b0);
    check("rst_out_data", out_data_s, 24'h000000);
    check("rst_out_sat", out_sat_s, 1'b0);
    check("rst_busy", busy_s, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Single beat and latency
    send_beat(16'h0005, 16'h0003, 1'b1, 0);
    check("lat_busy", busy_s, 1'b1);
    check("lat_valid_early", out_valid_s, 1'b0);
    check("lat_ready_low", in_ready_s, 1'b0);
    @(negedge clk);
    check("lat_valid", out_valid_s, 1'b1);
    check("single_data", out_data_s, 24'h000008);
    check("single_sat", out_sat_s, 1'b0);
    @(negedge clk);
    check("ready_after_hs", in_ready_s, 1'b1);
    check("valid_after_hs", out_valid_s, 1'b0);

    // Signed multi-beat: -12 + 15 + 256 = 259
    send_beat(16'hFFF0, 16'h0004, 1'b0, 0);
    send_beat(16'h0010, 16'hFFFF, 1'b0, 0);
    send_beat(16'h0100, 16'h0000, 1'b1, 0);
    drain();

    // Positive saturation / wrap: 300 x (7FFF + 7FFF)
    for (int i = 0; i < 300; i++) send_beat(16'h7FFF, 16'h7FFF, (i == 299), 0);
    drain();
    // Negative saturation / wrap: 200 x (8000 + 8000)
    for (int i = 0; i < 200; i++) send_beat(16'h8000, 16'h8000, (i == 199), 0);
    drain();

    // Backpressure: result 0x30 held while downstream stalls
    ready_mode = 0;
    send_beat(16'h0010, 16'h0020, 1'b1, 0);
    waited = 0;
    while (!out_valid_s && waited < 20) begin @(negedge clk); waited++; end
    if (!out_valid_s) fail_now("bp_valid_timeout");
    fork
      send_beat(16'h0007, 16'h0001, 1'b1, 0);
      begin
        for (int i = 0; i < 5; i++) begin
          check("bp_data_hold", out_data_s, 24'h000030);
          check("bp_valid_hold", out_valid_s, 1'b1);
          check("bp_in_ready", in_ready_s, 1'b0);
          @(negedge clk);
        end
        ready_mode = 1;
      end
    join
    drain();

    // Input stalls: gaps 0, 3, 7 -> 8
    send_beat(16'h0001, 16'h0001, 1'b0, 0);
    send_beat(16'h0001, 16'h0001, 1'b0, 0);
    send_beat(16'h0001, 16'h0001, 1'b0, 3);
    send_beat(16'h0001, 16'h0001, 1'b1, 7);
    drain();

    // Reset mid-packet, asserted between edges
    send_beat(16'h0100, 16'h0000, 1'b0, 0);
    send_beat(16'h0100, 16'h0000, 1'b0, 0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    model_acc = 0;
    #1;
    check("mid_rst_busy", busy_s, 1'b0);
    check("mid_rst_in_ready", in_ready_s, 1'b1);
    check("mid_rst_valid", out_valid_s, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send_beat(16'h0002, 16'h0001, 1'b1, 0);
    drain();

    // Randomized packets with random downstream ready
    ready_mode = 2;
    for (int p = 0; p < 40; p++) begin
      int len;
      len = $urandom_range(1, 8);
      for (int b = 0; b < len; b++) begin
        logic [IN_W-1:0] s, c;
        s = IN_W'($urandom);
        c = IN_W'($urandom);
        if ($urandom_range(0, 3) == 0) s = ($urandom_range(0, 1) != 0) ? 16'h7FFF : 16'h8000;
        send_beat(s, c, (b == len - 1), $urandom_range(0, 2));
      end
    end
    ready_mode = 1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
